// File: rtl/add_sub_arbiter.sv
// Two-requester round-robin arbiter sharing a single add/sub datapath.
// Define ADD_SUB_ARB_FIXED_PRIO_EN to make requester 0 always win contention.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_sub #(
    parameter int DATAW = 4
) (
    input  logic [DATAW-1:0] dataa,
    input  logic [DATAW-1:0] datab,
    input  logic             op,
    output logic [DATAW:0]   result
);
    logic [DATAW-1:0] datab_mod;
    logic [DATAW:0]   carry;

    // Subtraction inverts B and injects a carry of one; the extra result bit
    // is the sign-extended sum of the operand MSBs and the final carry.
    assign datab_mod     = datab ^ {DATAW{op}};
    assign carry[0]      = op;
    assign result[DATAW] = dataa[DATAW-1] ^ datab_mod[DATAW-1] ^ carry[DATAW];

    for (genvar i = 0; i < DATAW; i++) begin : g_bit
        full_adder u_fa (
            .a    (dataa[i]),
            .b    (datab_mod[i]),
            .cin  (carry[i]),
            .sum  (result[i]),
            .cout (carry[i+1])
        );
    end
endmodule

module add_sub_arbiter #(
    parameter int DATAW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [DATAW-1:0] i_req0_dataa,
    input  logic [DATAW-1:0] i_req0_datab,
    input  logic             i_req0_op,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [DATAW-1:0] i_req1_dataa,
    input  logic [DATAW-1:0] i_req1_datab,
    input  logic             i_req1_op,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [DATAW:0]   o_rsp_result
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [DATAW-1:0] dataa_q;
    logic [DATAW-1:0] datab_q;
    logic             op_q;
    logic             id_q;
    logic [DATAW:0]   sum;
    logic             grant_any;
    logic             grant_id;
`ifndef ADD_SUB_ARB_FIXED_PRIO_EN
    logic             last_grant;
`endif

    // Grant selection; ready is additionally held low while reset is asserted.
    always_comb begin
        grant_any = i_req0_valid | i_req1_valid;
`ifdef ADD_SUB_ARB_FIXED_PRIO_EN
        grant_id  = ~i_req0_valid;
`else
        grant_id  = (i_req0_valid & i_req1_valid) ? ~last_grant : ~i_req0_valid;
`endif
        o_req0_ready = rst_n && (state == IDLE) && i_req0_valid && !grant_id;
        o_req1_ready = rst_n && (state == IDLE) && i_req1_valid && grant_id;
    end

    add_sub #(.DATAW(DATAW)) u_add_sub (
        .dataa  (dataa_q),
        .datab  (datab_q),
        .op     (op_q),
        .result (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dataa_q      <= '0;
            datab_q      <= '0;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_result <= '0;
`ifndef ADD_SUB_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        dataa_q    <= grant_id ? i_req1_dataa : i_req0_dataa;
                        datab_q    <= grant_id ? i_req1_datab : i_req0_datab;
                        op_q       <= grant_id ? i_req1_op    : i_req0_op;
                        id_q       <= grant_id;
`ifndef ADD_SUB_ARB_FIXED_PRIO_EN
                        last_grant <= grant_id;
`endif
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    o_rsp_result <= sum;
                    o_rsp_id     <= id_q;
                    o_rsp_valid  <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
